// File: rtl/cntr_bank.sv
// Bank of NCH independent up/down counters with per-channel load, wrap/saturate
// mode, sticky overflow, compare-match pulse and a coherent bank-wide snapshot.
module cntr_bank #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = 32,
  parameter int unsigned IW  = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NCH-1:0]    ce_i,
  input  logic [NCH-1:0]    dn_i,
  input  logic [NCH*IW-1:0] inc_i,
  input  logic [NCH-1:0]    sat_i,
  input  logic [NCH-1:0]    ld_i,
  input  logic [NCH*CW-1:0] ld_val_i,
  input  logic [NCH*CW-1:0] cmp_i,
  input  logic [NCH-1:0]    ovf_clr_i,
  input  logic              snap_i,
  output logic [NCH*CW-1:0] cnt_o,
  output logic [NCH-1:0]    ovf_o,
  output logic [NCH-1:0]    hit_o,
  output logic [NCH*CW-1:0] snap_o,
  output logic              snap_vld_o
);

  logic snap_vld_q;

  for (genvar k = 0; k < int'(NCH); k++) begin : g_ch
    logic [CW-1:0] cnt_q, cnt_d, inc, snap_q;
    logic [CW:0]   sum;
    logic          ovf_q, hit_q, ovf_ev, hit_d, upd;

    always_comb begin
      inc    = CW'(inc_i[k*IW +: IW]);
      // Bit CW of the extended difference is the borrow, i.e. inc > cnt.
      sum    = dn_i[k] ? ({1'b0, cnt_q} - {1'b0, inc})
                       : ({1'b0, cnt_q} + {1'b0, inc});
      cnt_d  = cnt_q;
      ovf_ev = 1'b0;
      upd    = 1'b0;
      if (ld_i[k]) begin
        cnt_d = ld_val_i[k*CW +: CW];
        upd   = 1'b1;
      end else if (ce_i[k]) begin
        upd    = 1'b1;
        ovf_ev = sum[CW];
        if (sat_i[k] && sum[CW]) cnt_d = dn_i[k] ? '0 : '1;
        else                     cnt_d = sum[CW-1:0];
      end
      hit_d = upd && (cnt_d == cmp_i[k*CW +: CW]) && (cnt_d != cnt_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q  <= '0;
        ovf_q  <= 1'b0;
        hit_q  <= 1'b0;
        snap_q <= '0;
      end else begin
        cnt_q <= cnt_d;
        ovf_q <= ovf_ev | (ovf_q & ~ovf_clr_i[k]);
        hit_q <= hit_d;
        if (snap_i) snap_q <= cnt_q;
      end
    end

    assign cnt_o[k*CW +: CW]  = cnt_q;
    assign snap_o[k*CW +: CW] = snap_q;
    assign ovf_o[k]           = ovf_q;
    assign hit_o[k]           = hit_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) snap_vld_q <= 1'b0;
    else         snap_vld_q <= snap_i;
  end

  assign snap_vld_o = snap_vld_q;

endmodule

// File: tb/tb_cntr_bank.sv
// Directed and randomized bench for cntr_bank against an integer-arithmetic
// reference model of the counter bank.
module tb_cntr_bank;
  localparam int NCH  = 4;
  localparam int CW   = 8;
  localparam int IW   = 4;
  localparam int MAXV = (1 << CW) - 1;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [NCH-1:0]    ce_i, dn_i, sat_i, ld_i, ovf_clr_i;
  logic [NCH*IW-1:0] inc_i;
  logic [NCH*CW-1:0] ld_val_i, cmp_i;
  logic              snap_i;
  logic [NCH*CW-1:0] cnt_o, snap_o;
  logic [NCH-1:0]    ovf_o, hit_o;
  logic              snap_vld_o;

  cntr_bank #(.NCH(NCH), .CW(CW), .IW(IW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .ce_i(ce_i), .dn_i(dn_i), .inc_i(inc_i),
    .sat_i(sat_i), .ld_i(ld_i), .ld_val_i(ld_val_i), .cmp_i(cmp_i),
    .ovf_clr_i(ovf_clr_i), .snap_i(snap_i), .cnt_o(cnt_o), .ovf_o(ovf_o),
    .hit_o(hit_o), .snap_o(snap_o), .snap_vld_o(snap_vld_o)
  );

  always #5 clk_i = ~clk_i;

  int n_assert = 0;
  int n_fail   = 0;

  int m_cnt[NCH];
  int m_snap[NCH];
  bit m_ovf[NCH];
  bit m_hit[NCH];
  bit m_vld;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_cnt[k] = 0; m_snap[k] = 0; m_ovf[k] = 0; m_hit[k] = 0;
    end
    m_vld = 0;
  endtask

  task automatic check_all(input string tag);
    logic [NCH*CW-1:0] ec, es;
    logic [NCH-1:0]    eo, eh;
    for (int k = 0; k < NCH; k++) begin
      ec[k*CW +: CW] = CW'(m_cnt[k]);
      es[k*CW +: CW] = CW'(m_snap[k]);
      eo[k] = m_ovf[k];
      eh[k] = m_hit[k];
    end
    check({tag, ".cnt"},  64'(cnt_o),      64'(ec));
    check({tag, ".ovf"},  64'(ovf_o),      64'(eo));
    check({tag, ".hit"},  64'(hit_o),      64'(eh));
    check({tag, ".snap"}, 64'(snap_o),     64'(es));
    check({tag, ".vld"},  64'(snap_vld_o), 64'(m_vld));
  endtask

  // One clock: model evaluates current inputs, then the edge, then compare.
  task automatic step(input string tag);
    int nc[NCH];
    bit no[NCH], nh[NCH];
    for (int k = 0; k < NCH; k++) begin
      int old, inc, t;
      bit ev, upd;
      old = m_cnt[k]; inc = int'(inc_i[k*IW +: IW]);
      nc[k] = old; ev = 0; upd = 0;
      if (ld_i[k]) begin
        nc[k] = int'(ld_val_i[k*CW +: CW]); upd = 1;
      end else if (ce_i[k]) begin
        upd = 1;
        t = dn_i[k] ? old - inc : old + inc;
        if (t < 0) begin
          ev = 1; nc[k] = sat_i[k] ? 0 : t + MAXV + 1;
        end else if (t > MAXV) begin
          ev = 1; nc[k] = sat_i[k] ? MAXV : t - MAXV - 1;
        end else nc[k] = t;
      end
      nh[k] = upd && nc[k] == int'(cmp_i[k*CW +: CW]) && nc[k] != old;
      no[k] = ev || (m_ovf[k] && !ovf_clr_i[k]);
    end
    if (snap_i) for (int k = 0; k < NCH; k++) m_snap[k] = m_cnt[k];
    m_vld = snap_i;
    @(posedge clk_i);
    #1;
    for (int k = 0; k < NCH; k++) begin
      m_cnt[k] = nc[k]; m_ovf[k] = no[k]; m_hit[k] = nh[k];
    end
    check_all(tag);
  endtask

  task automatic idle();
    ce_i = '0; dn_i = '0; sat_i = '0; ld_i = '0; ovf_clr_i = '0;
    inc_i = '0; ld_val_i = '0; snap_i = 1'b0;
  endtask

  initial begin
    idle();
    cmp_i  = '1;
    rst_ni = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check_all("reset");
    rst_ni = 1'b1;

    // Activity, then asynchronous reset in mid-cycle
    ce_i = '1; inc_i = {4'd7, 4'd5, 4'd3, 4'd1}; snap_i = 1'b1;
    repeat (3) step("pre_rst");
    #2 rst_ni = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    idle();
    #2 rst_ni = 1'b1;
    step("post_rst");
    step("post_rst2");
    check("post_rst_cnt", 64'(cnt_o), 64'd0);

    // Wrap up with overflow; set beats clear
    ld_i[0] = 1'b1; ld_val_i[7:0] = 8'hFE; step("wrap_ld");
    ld_i[0] = 1'b0; ce_i[0] = 1'b1; inc_i[3:0] = 4'd3; step("wrap_ce");
    check("wrap_val", 64'(cnt_o[7:0]), 64'h01);
    check("wrap_ovf", 64'(ovf_o[0]), 64'd1);
    ce_i[0] = 1'b0; ld_i[0] = 1'b1; step("wrap_ld2");
    ld_i[0] = 1'b0; ce_i[0] = 1'b1; ovf_clr_i[0] = 1'b1; step("set_vs_clr");
    check("set_beats_clr", 64'(ovf_o[0]), 64'd1);
    ce_i[0] = 1'b0; step("clr_only");
    check("clr_alone", 64'(ovf_o[0]), 64'd0);
    ovf_clr_i[0] = 1'b0;

    // Saturate at both rails
    sat_i[0] = 1'b1; ld_i[0] = 1'b1; ld_val_i[7:0] = 8'h03; step("sat_ld");
    ld_i[0] = 1'b0; ce_i[0] = 1'b1; dn_i[0] = 1'b1; inc_i[3:0] = 4'd5; step("sat_dn");
    check("sat_lo", 64'(cnt_o[7:0]), 64'h00);
    check("sat_lo_ovf", 64'(ovf_o[0]), 64'd1);
    ce_i[0] = 1'b0; ovf_clr_i[0] = 1'b1; step("sat_clr");
    ovf_clr_i[0] = 1'b0; ld_i[0] = 1'b1; ld_val_i[7:0] = 8'hFD; dn_i[0] = 1'b0;
    cmp_i[7:0] = 8'hFF; step("sat_ld2");
    ld_i[0] = 1'b0; ce_i[0] = 1'b1; step("sat_up");
    check("sat_hi", 64'(cnt_o[7:0]), 64'hFF);
    check("sat_hi_hit", 64'(hit_o[0]), 64'd1);
    step("sat_rail");
    check("sat_rail_nohit", 64'(hit_o[0]), 64'd0);
    check("sat_rail_ovf", 64'(ovf_o[0]), 64'd1);

    // Load beats count
    ld_i[0] = 1'b1; ld_val_i[7:0] = 8'h40; step("prio");
    check("prio_val", 64'(cnt_o[7:0]), 64'h40);

    // Compare pulse behaviour
    idle(); cmp_i[7:0] = 8'h10;
    ld_i[0] = 1'b1; ld_val_i[7:0] = 8'h0E; step("cmp_ld");
    ld_i[0] = 1'b0; ce_i[0] = 1'b1; inc_i[3:0] = 4'd1; step("cmp_0f");
    step("cmp_10");
    check("cmp_hit", 64'(hit_o[0]), 64'd1);
    ce_i[0] = 1'b0; step("cmp_hold");
    ce_i[0] = 1'b1; inc_i[3:0] = 4'd0; step("cmp_inc0");
    check("cmp_inc0_nohit", 64'(hit_o[0]), 64'd0);
    cmp_i[7:0] = 8'h11; step("cmp_chg");
    cmp_i[7:0] = 8'h10; ce_i[0] = 1'b0;
    ld_i[0] = 1'b1; ld_val_i[7:0] = 8'h05; step("cmp_ld05");
    ld_val_i[7:0] = 8'h10; step("cmp_ld10");
    check("cmp_ld_hit", 64'(hit_o[0]), 64'd1);
    step("cmp_ld10_again");
    check("cmp_ld_nohit", 64'(hit_o[0]), 64'd0);

    // Snapshot of all counting channels; single and back-to-back
    idle(); ce_i = '1; inc_i = {4'd9, 4'd6, 4'd2, 4'd1};
    step("snap_pre");
    snap_i = 1'b1; step("snap_n");
    snap_i = 1'b0; step("snap_n1");
    check("snap_vld_drop", 64'(snap_vld_o), 64'd0);
    snap_i = 1'b1; step("snap_b2b0"); step("snap_b2b1");
    check("snap_vld_b2b", 64'(snap_vld_o), 64'd1);
    snap_i = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < NCH; k++) begin
        ce_i[k]      = ($urandom_range(0, 3) != 0);
        dn_i[k]      = 1'($urandom_range(0, 1));
        sat_i[k]     = 1'($urandom_range(0, 1));
        ld_i[k]      = ($urandom_range(0, 7) == 0);
        ovf_clr_i[k] = ($urandom_range(0, 5) == 0);
        inc_i[k*IW +: IW]    = IW'($urandom_range(0, 15));
        ld_val_i[k*CW +: CW] = CW'($urandom);
        if ($urandom_range(0, 1) == 1)
          cmp_i[k*CW +: CW] = CW'(m_cnt[k] + (dn_i[k] ? -1 : 1) * int'(inc_i[k*IW +: IW]));
        else
          cmp_i[k*CW +: CW] = CW'($urandom);
      end
      snap_i = ($urandom_range(0, 4) == 0);
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
